// File: rtl/alu_pipe.sv
// alu_pipe: two-stage handshaked ALU (arith/logic/cmp/shift) with a merged result bus.
// The iterative signed divider is built only when ALU_DIV_EN is defined.
module alu_pipe #(
    parameter int WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [3:0]           ALU_FUN,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic [2*WIDTH-1:0]   ALU_OUT,
    output logic                 Carry_OUT,
    output logic [3:0]           Unit_Flag,
    output logic                 Zero_Flag,
    output logic                 Div_Err
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW:0] WIDTH_C = (SHW+1)'(WIDTH);

    logic                 rst_done_r;
    logic                 s1_valid_r;
    logic [WIDTH-1:0]     s1_a_r;
    logic [WIDTH-1:0]     s1_b_r;
    logic [3:0]           s1_fun_r;
    logic                 s1_done_s;
    logic                 in_fire_s;
    logic                 s2_load_s;

    logic                 out_valid_r;
    logic [2*WIDTH-1:0]   alu_out_r;
    logic                 carry_r;
    logic [3:0]           unit_r;
    logic                 zero_r;
    logic                 div_err_r;

    logic [2*WIDTH-1:0]   res_s;
    logic                 carry_s;
    logic                 err_s;
    logic [3:0]           flag_s;

    logic [WIDTH:0]       add_u_s;
    logic                 add_sign_s;
    logic [2*WIDTH-1:0]   a_ext_s;
    logic [2*WIDTH-1:0]   b_ext_s;
    logic [2*WIDTH-1:0]   prod_s;
    logic [SHW-1:0]       sh_s;
    logic [SHW:0]         rsh_s;
    logic [WIDTH-1:0]     srl_s;
    logic [WIDTH-1:0]     sll_s;
    logic [WIDTH-1:0]     sra_s;
    logic [WIDTH-1:0]     rol_s;

    assign in_fire_s = IN_VALID && IN_READY;
    assign s2_load_s = s1_valid_r && s1_done_s && (!out_valid_r || OUT_READY);
    assign IN_READY  = RST && rst_done_r && (!s1_valid_r || (s1_done_s && (!out_valid_r || OUT_READY)));

    // The signed (W+1)-bit sum shares low bits with the unsigned one; only its sign bit differs.
    assign add_u_s    = s1_fun_r[0] ? ({1'b0, s1_a_r} - {1'b0, s1_b_r})
                                    : ({1'b0, s1_a_r} + {1'b0, s1_b_r});
    assign add_sign_s = s1_a_r[WIDTH-1] ^ s1_b_r[WIDTH-1] ^ add_u_s[WIDTH];
    assign a_ext_s    = {{WIDTH{s1_a_r[WIDTH-1]}}, s1_a_r};
    assign b_ext_s    = {{WIDTH{s1_b_r[WIDTH-1]}}, s1_b_r};
    assign prod_s     = a_ext_s * b_ext_s;
    assign sh_s       = s1_b_r[SHW-1:0];
    assign rsh_s      = WIDTH_C - {1'b0, sh_s};
    assign srl_s      = s1_a_r >> sh_s;
    assign sll_s      = s1_a_r << sh_s;
    assign sra_s      = $signed(s1_a_r) >>> sh_s;
    assign rol_s      = (s1_a_r << sh_s) | (s1_a_r >> rsh_s);

`ifdef ALU_DIV_EN
    localparam logic [SHW-1:0] CNT_ONE = {{(SHW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    div_state_t           div_state_r;
    div_state_t           div_state_s;
    logic [WIDTH-1:0]     div_rem_r;
    logic [WIDTH-1:0]     div_quo_r;
    logic [WIDTH-1:0]     div_dvs_r;
    logic [SHW-1:0]       div_cnt_r;
    logic                 is_div_s;
    logic                 b_zero_s;
    logic [WIDTH-1:0]     a_mag_s;
    logic [WIDTH-1:0]     b_mag_s;
    logic [WIDTH:0]       div_shift_s;
    logic                 div_ge_s;
    logic [WIDTH-1:0]     div_diff_s;
    logic [WIDTH-1:0]     quo_fix_s;
    logic [WIDTH-1:0]     rem_fix_s;

    assign is_div_s    = (s1_fun_r == 4'b0011);
    assign b_zero_s    = (s1_b_r == {WIDTH{1'b0}});
    assign a_mag_s     = s1_a_r[WIDTH-1] ? -s1_a_r : s1_a_r;
    assign b_mag_s     = s1_b_r[WIDTH-1] ? -s1_b_r : s1_b_r;
    assign div_shift_s = {div_rem_r, div_quo_r[WIDTH-1]};
    assign div_ge_s    = (div_shift_s >= {1'b0, div_dvs_r});
    assign div_diff_s  = div_shift_s[WIDTH-1:0] - div_dvs_r;
    assign quo_fix_s   = (s1_a_r[WIDTH-1] ^ s1_b_r[WIDTH-1]) ? -div_quo_r : div_quo_r;
    assign rem_fix_s   = s1_a_r[WIDTH-1] ? -div_rem_r : div_rem_r;

    // Divider state register
    always_ff @(posedge CLK) begin
        if (!RST) begin
            div_state_r <= DIV_IDLE;
        end else begin
            div_state_r <= div_state_s;
        end
    end

    // Divider next-state: a zero divisor never leaves IDLE
    always_comb begin
        div_state_s = div_state_r;
        case (div_state_r)
            DIV_IDLE: begin
                if (s1_valid_r && is_div_s && !b_zero_s) div_state_s = DIV_BUSY;
                else                                     div_state_s = DIV_IDLE;
            end
            DIV_BUSY: begin
                if (div_cnt_r == {SHW{1'b0}}) div_state_s = DIV_DONE;
                else                          div_state_s = DIV_BUSY;
            end
            DIV_DONE: begin
                if (s2_load_s) div_state_s = DIV_IDLE;
                else           div_state_s = DIV_DONE;
            end
            default: div_state_s = DIV_IDLE;
        endcase
    end

    // Restoring iteration on operand magnitudes, one quotient bit per cycle
    always_ff @(posedge CLK) begin
        if (!RST) begin
            div_rem_r <= {WIDTH{1'b0}};
            div_quo_r <= {WIDTH{1'b0}};
            div_dvs_r <= {WIDTH{1'b0}};
            div_cnt_r <= {SHW{1'b0}};
        end else if (div_state_r == DIV_IDLE && div_state_s == DIV_BUSY) begin
            div_rem_r <= {WIDTH{1'b0}};
            div_quo_r <= a_mag_s;
            div_dvs_r <= b_mag_s;
            div_cnt_r <= SHW'(WIDTH-1);
        end else if (div_state_r == DIV_BUSY) begin
            div_rem_r <= div_ge_s ? div_diff_s : div_shift_s[WIDTH-1:0];
            div_quo_r <= {div_quo_r[WIDTH-2:0], div_ge_s};
            div_cnt_r <= div_cnt_r - CNT_ONE;
        end
    end

    // S1 result is ready immediately except for a nonzero-divisor DIV
    always_comb begin
        s1_done_s = 1'b1;
        if (is_div_s && !b_zero_s) s1_done_s = (div_state_r == DIV_DONE);
        else                       s1_done_s = 1'b1;
    end
`else
    assign s1_done_s = 1'b1;
`endif

    // Result/flag mux for the operation held in S1
    always_comb begin
        res_s   = {(2*WIDTH){1'b0}};
        carry_s = 1'b0;
        err_s   = 1'b0;
        case (s1_fun_r[3:2])
            2'b00:   flag_s = 4'b0001;
            2'b01:   flag_s = 4'b0010;
            2'b10:   flag_s = 4'b0100;
            2'b11:   flag_s = 4'b1000;
            default: flag_s = 4'b0000;
        endcase
        case (s1_fun_r)
            4'b0000, 4'b0001: begin
                res_s   = {{WIDTH{add_sign_s}}, add_u_s[WIDTH-1:0]};
                carry_s = add_u_s[WIDTH];
            end
            4'b0010: res_s = prod_s;
            4'b0011: begin
`ifdef ALU_DIV_EN
                if (b_zero_s) begin
                    res_s = {s1_a_r, {WIDTH{1'b1}}};
                    err_s = 1'b1;
                end else begin
                    res_s = {rem_fix_s, quo_fix_s};
                    err_s = 1'b0;
                end
`else
                res_s = {(2*WIDTH){1'b0}};
                err_s = 1'b1;
`endif
            end
            4'b0100: res_s = {{WIDTH{1'b0}}, s1_a_r & s1_b_r};
            4'b0101: res_s = {{WIDTH{1'b0}}, s1_a_r | s1_b_r};
            4'b0110: res_s = {{WIDTH{1'b0}}, ~(s1_a_r & s1_b_r)};
            4'b0111: res_s = {{WIDTH{1'b0}}, ~(s1_a_r | s1_b_r)};
            4'b1000: res_s = {{(2*WIDTH-2){1'b0}}, (s1_a_r == s1_b_r) ? 2'b01 : 2'b00};
            4'b1001: res_s = {{(2*WIDTH-2){1'b0}}, ($signed(s1_a_r) > $signed(s1_b_r)) ? 2'b10 : 2'b00};
            4'b1010: res_s = {{(2*WIDTH-2){1'b0}}, ($signed(s1_a_r) < $signed(s1_b_r)) ? 2'b11 : 2'b00};
            4'b1100: res_s = {{WIDTH{1'b0}}, srl_s};
            4'b1101: res_s = {{WIDTH{1'b0}}, sll_s};
            4'b1110: res_s = {{WIDTH{1'b0}}, sra_s};
            4'b1111: res_s = {{WIDTH{1'b0}}, rol_s};
            default: res_s = {(2*WIDTH){1'b0}};
        endcase
    end

    // Holds IN_READY low until the first edge after reset release
    always_ff @(posedge CLK) begin
        if (!RST) rst_done_r <= 1'b0;
        else      rst_done_r <= 1'b1;
    end

    // S1 issue register
    always_ff @(posedge CLK) begin
        if (!RST) begin
            s1_valid_r <= 1'b0;
            s1_a_r     <= {WIDTH{1'b0}};
            s1_b_r     <= {WIDTH{1'b0}};
            s1_fun_r   <= 4'b0000;
        end else if (in_fire_s) begin
            s1_valid_r <= 1'b1;
            s1_a_r     <= A;
            s1_b_r     <= B;
            s1_fun_r   <= ALU_FUN;
        end else if (s2_load_s) begin
            s1_valid_r <= 1'b0;
        end
    end

    // S2 output register; a reload in the same cycle as a transfer leaves no bubble
    always_ff @(posedge CLK) begin
        if (!RST) begin
            out_valid_r <= 1'b0;
            alu_out_r   <= {(2*WIDTH){1'b0}};
            carry_r     <= 1'b0;
            unit_r      <= 4'b0000;
            zero_r      <= 1'b0;
            div_err_r   <= 1'b0;
        end else if (s2_load_s) begin
            out_valid_r <= 1'b1;
            alu_out_r   <= res_s;
            carry_r     <= carry_s;
            unit_r      <= flag_s;
            zero_r      <= (res_s == {(2*WIDTH){1'b0}});
            div_err_r   <= err_s;
        end else if (OUT_READY) begin
            out_valid_r <= 1'b0;
        end
    end

    assign OUT_VALID = out_valid_r;
    assign ALU_OUT   = alu_out_r;
    assign Carry_OUT = carry_r;
    assign Unit_Flag = unit_r;
    assign Zero_Flag = zero_r;
    assign Div_Err   = div_err_r;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed, table-driven bench for alu_pipe (WIDTH=16); DIV expectations follow ALU_DIV_EN.
module tb_alu_pipe;
    localparam int W = 16;

    logic            CLK = 1'b0;
    logic            RST;
    logic [W-1:0]    A;
    logic [W-1:0]    B;
    logic [3:0]      ALU_FUN;
    logic            IN_VALID;
    logic            IN_READY;
    logic            OUT_VALID;
    logic            OUT_READY;
    logic [2*W-1:0]  ALU_OUT;
    logic            Carry_OUT;
    logic [3:0]      Unit_Flag;
    logic            Zero_Flag;
    logic            Div_Err;

    alu_pipe #(.WIDTH(W)) dut (
        .CLK(CLK), .RST(RST), .A(A), .B(B), .ALU_FUN(ALU_FUN),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .ALU_OUT(ALU_OUT), .Carry_OUT(Carry_OUT), .Unit_Flag(Unit_Flag),
        .Zero_Flag(Zero_Flag), .Div_Err(Div_Err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0]  fun;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] out;
        logic        carry;
        logic [3:0]  flag;
        logic        err;
        int          lat;
        logic        busy;
    } vec_t;

    vec_t vecs[$];
    int n_checks = 0;
    int n_miss   = 0;

    logic [3:0]  tp_fun [4] = '{4'b0010, 4'b0100, 4'b1110, 4'b1010};
    logic [15:0] tp_a   [4] = '{16'hFFFD, 16'hFF0F, 16'h8400, 16'hFFFE};
    logic [15:0] tp_b   [4] = '{16'h0005, 16'h0FF0, 16'h0002, 16'h0001};
    logic [31:0] tp_exp [4] = '{32'hFFFFFFF1, 32'h00000F00, 32'h0000E100, 32'h00000003};

    function automatic vec_t mk(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                                input logic [31:0] o, input logic c, input logic [3:0] fl,
                                input logic e, input int l, input logic bz);
        vec_t v;
        v.fun = f; v.a = a; v.b = b; v.out = o; v.carry = c;
        v.flag = fl; v.err = e; v.lat = l; v.busy = bz;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_miss++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Called at a negedge; returns #1 after the accept edge.
    task automatic issue(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
        int n = 0;
        IN_VALID = 1'b1; ALU_FUN = f; A = a; B = b;
        while (!IN_READY && n < 60) begin
            @(negedge CLK);
            n++;
        end
        if (!IN_READY) timeout_fail("issue_timeout");
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
    endtask

    // Counts edges from the accept edge until OUT_VALID is seen.
    task automatic collect(output int lat, output logic ready_seen);
        lat = 1;
        ready_seen = 1'b0;
        @(negedge CLK);
        while (!OUT_VALID && lat < 60) begin
            if (IN_READY) ready_seen = 1'b1;
            @(negedge CLK);
            lat++;
        end
        if (!OUT_VALID) timeout_fail("out_timeout");
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_valid"}, {31'd0, OUT_VALID}, 32'd0);
        chk({tag, "_out"},   ALU_OUT, 32'd0);
        chk({tag, "_carry"}, {31'd0, Carry_OUT}, 32'd0);
        chk({tag, "_unit"},  {28'd0, Unit_Flag}, 32'd0);
        chk({tag, "_zero"},  {31'd0, Zero_Flag}, 32'd0);
        chk({tag, "_derr"},  {31'd0, Div_Err}, 32'd0);
        chk({tag, "_ready"}, {31'd0, IN_READY}, 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        logic rs;
        logic seen;
        logic [31:0] dexp;
        logic        derr;

        RST = 1'b0; IN_VALID = 1'b0; A = 16'h0000; B = 16'h0000;
        ALU_FUN = 4'b0000; OUT_READY = 1'b1;
        repeat (3) @(negedge CLK);
        chk_reset_state("rst0");
        RST = 1'b1;
        chk("rst0_ready_release", {31'd0, IN_READY}, 32'd0);
        @(negedge CLK);
        chk("rst0_ready_after", {31'd0, IN_READY}, 32'd1);

        vecs.push_back(mk(4'b0000, 16'h7FFF, 16'h0001, 32'h00008000, 1'b0, 4'b0001, 1'b0, 2, 1'b0));
        vecs.push_back(mk(4'b0001, 16'h0000, 16'h0001, 32'hFFFFFFFF, 1'b1, 4'b0001, 1'b0, 2, 1'b0));
        vecs.push_back(mk(4'b0000, 16'hFFFF, 16'h0001, 32'h00000000, 1'b1, 4'b0001, 1'b0, 2, 1'b0));
        vecs.push_back(mk(4'b0001, 16'h0005, 16'h0003, 32'h00000002, 1'b0, 4'b0001, 1'b0, 2, 1'b0));
        vecs.push_back(mk(4'b0000, 16'h8000, 16'h8000, 32'hFFFF0000, 1'b1, 4'b0001, 1'b0, 2, 1'b0));
        vecs.push_back(mk(4'b0010, 16'hFFFD, 16'h0005, 32'hFFFFFFF1, 1'b0, 4'b0001, 1'b0, 2, 1'b0));
        vecs.push_back(mk(4'b0010, 16'h7FFF, 16'h7FFF, 32'h3FFF0001, 1'b0, 4'b0001, 1'b0, 2, 1'b0));
        vecs.push_back(mk(4'b0010, 16'h8000, 16'h8000, 32'h40000000, 1'b0, 4'b0001, 1'b0, 2, 1'b0));
        vecs.push_back(mk(4'b0100, 16'hF0F0, 16'h0FF0, 32'h000000F0, 1'b0, 4'b0010, 1'b0, 2, 1'b0));
        vecs.push_back(mk(4'b0101, 16'h1200, 16'h0034, 32'h00001234, 1'b0, 4'b0010, 1'b0, 2, 1'b0));
        vecs.push_back(mk(4'b0110, 16'hFFFF, 16'hFFFF, 32'h00000000, 1'b0, 4'b0010, 1'b0, 2, 1'b0));
        vecs.push_back(mk(4'b0111, 16'h0000, 16'h0000, 32'h0000FFFF, 1'b0, 4'b0010, 1'b0, 2, 1'b0));
        vecs.push_back(mk(4'b1000, 16'h0005, 16'h0005, 32'h00000001, 1'b0, 4'b0100, 1'b0, 2, 1'b0));
        vecs.push_back(mk(4'b1001, 16'h0001, 16'hFFFF, 32'h00000002, 1'b0, 4'b0100, 1'b0, 2, 1'b0));
        vecs.push_back(mk(4'b1010, 16'h8000, 16'h0001, 32'h00000003, 1'b0, 4'b0100, 1'b0, 2, 1'b0));
        vecs.push_back(mk(4'b1010, 16'h0005, 16'h0003, 32'h00000000, 1'b0, 4'b0100, 1'b0, 2, 1'b0));
        vecs.push_back(mk(4'b1011, 16'h0005, 16'h0005, 32'h00000000, 1'b0, 4'b0100, 1'b0, 2, 1'b0));
        vecs.push_back(mk(4'b1100, 16'h8001, 16'h0001, 32'h00004000, 1'b0, 4'b1000, 1'b0, 2, 1'b0));
        vecs.push_back(mk(4'b1101, 16'h0001, 16'hFFF4, 32'h00000010, 1'b0, 4'b1000, 1'b0, 2, 1'b0));
        vecs.push_back(mk(4'b1110, 16'h8000, 16'h0003, 32'h0000F000, 1'b0, 4'b1000, 1'b0, 2, 1'b0));
        vecs.push_back(mk(4'b1111, 16'h8001, 16'h0001, 32'h00000003, 1'b0, 4'b1000, 1'b0, 2, 1'b0));
        vecs.push_back(mk(4'b1111, 16'h1234, 16'h0004, 32'h00002341, 1'b0, 4'b1000, 1'b0, 2, 1'b0));
`ifdef ALU_DIV_EN
        vecs.push_back(mk(4'b0011, 16'hFFF9, 16'h0002, 32'hFFFFFFFD, 1'b0, 4'b0001, 1'b0, 19, 1'b1));
        vecs.push_back(mk(4'b0011, 16'h0005, 16'h0000, 32'h0005FFFF, 1'b0, 4'b0001, 1'b1, 2, 1'b0));
        vecs.push_back(mk(4'b0011, 16'h0007, 16'hFFFE, 32'h0001FFFD, 1'b0, 4'b0001, 1'b0, 19, 1'b1));
        vecs.push_back(mk(4'b0011, 16'h8000, 16'hFFFF, 32'h00008000, 1'b0, 4'b0001, 1'b0, 19, 1'b1));
        vecs.push_back(mk(4'b0011, 16'h0064, 16'h0007, 32'h0002000E, 1'b0, 4'b0001, 1'b0, 19, 1'b1));
`else
        vecs.push_back(mk(4'b0011, 16'hFFF9, 16'h0002, 32'h00000000, 1'b0, 4'b0001, 1'b1, 2, 1'b0));
        vecs.push_back(mk(4'b0011, 16'h0005, 16'h0000, 32'h00000000, 1'b0, 4'b0001, 1'b1, 2, 1'b0));
`endif

        foreach (vecs[i]) begin
            issue(vecs[i].fun, vecs[i].a, vecs[i].b);
            collect(lat, rs);
            chk($sformatf("v%0d_out", i),   ALU_OUT, vecs[i].out);
            chk($sformatf("v%0d_carry", i), {31'd0, Carry_OUT}, {31'd0, vecs[i].carry});
            chk($sformatf("v%0d_unit", i),  {28'd0, Unit_Flag}, {28'd0, vecs[i].flag});
            chk($sformatf("v%0d_zero", i),  {31'd0, Zero_Flag}, {31'd0, (vecs[i].out == 32'd0)});
            chk($sformatf("v%0d_derr", i),  {31'd0, Div_Err}, {31'd0, vecs[i].err});
            chk($sformatf("v%0d_lat", i),   lat, vecs[i].lat);
            if (vecs[i].busy) chk($sformatf("v%0d_ready_busy", i), {31'd0, rs}, 32'd0);
        end
        @(negedge CLK);
        chk("drain_valid", {31'd0, OUT_VALID}, 32'd0);

        // Back-to-back issue: one result per cycle, in order.
        for (int k = 0; k < 6; k++) begin
            if (k >= 2) begin
                chk($sformatf("tp%0d_valid", k - 2), {31'd0, OUT_VALID}, 32'd1);
                chk($sformatf("tp%0d_out", k - 2), ALU_OUT, tp_exp[k - 2]);
            end
            if (k < 4) begin
                IN_VALID = 1'b1; ALU_FUN = tp_fun[k]; A = tp_a[k]; B = tp_b[k];
                chk($sformatf("tp%0d_ready", k), {31'd0, IN_READY}, 32'd1);
            end else begin
                IN_VALID = 1'b0;
            end
            @(negedge CLK);
        end
        chk("tp_end_valid", {31'd0, OUT_VALID}, 32'd0);

        // Backpressure: result held, second op parked in S1, then reloaded without a bubble.
        OUT_READY = 1'b0;
        issue(4'b0000, 16'h1111, 16'h2222);
        collect(lat, rs);
        chk("bp_first_out", ALU_OUT, 32'h00003333);
        issue(4'b0101, 16'h00A0, 16'h000B);
        @(negedge CLK);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("bp_hold%0d_out", k), ALU_OUT, 32'h00003333);
            chk($sformatf("bp_hold%0d_valid", k), {31'd0, OUT_VALID}, 32'd1);
            chk($sformatf("bp_hold%0d_ready", k), {31'd0, IN_READY}, 32'd0);
            @(negedge CLK);
        end
        OUT_READY = 1'b1;
        @(negedge CLK);
        chk("bp_next_out", ALU_OUT, 32'h000000AB);
        chk("bp_next_valid", {31'd0, OUT_VALID}, 32'd1);
        @(negedge CLK);
        chk("bp_end_valid", {31'd0, OUT_VALID}, 32'd0);

        // DIV under backpressure.
`ifdef ALU_DIV_EN
        dexp = 32'h00000003; derr = 1'b0;
`else
        dexp = 32'h00000000; derr = 1'b1;
`endif
        OUT_READY = 1'b0;
        issue(4'b0011, 16'h0009, 16'h0003);
        collect(lat, rs);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("bpd%0d_out", k), ALU_OUT, dexp);
            chk($sformatf("bpd%0d_derr", k), {31'd0, Div_Err}, {31'd0, derr});
            chk($sformatf("bpd%0d_valid", k), {31'd0, OUT_VALID}, 32'd1);
            @(negedge CLK);
        end
        OUT_READY = 1'b1;
        @(negedge CLK);
        chk("bpd_end_valid", {31'd0, OUT_VALID}, 32'd0);

        // Reset while an op is in flight: aborted and never retried.
        issue(4'b0011, 16'hFFF9, 16'h0002);
        @(negedge CLK);
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        chk_reset_state("rst1");
        RST = 1'b1;
        chk("rst1_ready_release", {31'd0, IN_READY}, 32'd0);
        @(negedge CLK);
        chk("rst1_ready_after", {31'd0, IN_READY}, 32'd1);
        seen = 1'b0;
        repeat (25) begin
            @(negedge CLK);
            if (OUT_VALID) seen = 1'b1;
        end
        chk("rst1_no_retry", {31'd0, seen}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_miss);
        $finish;
    end
endmodule

// File: doc/alu_pipe.md
# alu_pipe

Second-generation arithmetic/logic unit for the datapath, replacing the fixed-width four-unit ALU with one parametrised, handshaked, two-stage pipeline. It decodes the same 4-bit function code (unit select in [3:2], operation in [1:0]), adds an iterative signed divider that stalls the pipe, and merges all unit outputs onto one result bus with a one-hot unit flag. It sits between the register-file read stage and the writeback stage and is the only ALU instance in the datapath.

## Interface
- WIDTH, 16, operand width in bits; legal range 4..32.
- SHW, $clog2(WIDTH), shift-amount bits taken from B; derived, not overridden.

- CLK  in  1  clock; all logic rising-edge.
- RST  in  1  synchronous, active-low reset.
- A, B  in  WIDTH  signed operands.
- ALU_FUN  in  4  function code; [3:2] unit (00 arith, 01 logic, 10 cmp, 11 shift), [1:0] op.
- IN_VALID / IN_READY  in / out  1  operand handshake; transfer when both are high at a rising edge.
- OUT_VALID / OUT_READY  out / in  1  result handshake; transfer when both are high.
- ALU_OUT  out  2*WIDTH  result.
- Carry_OUT  out  1  carry/borrow of ADD/SUB; 0 otherwise.
- Unit_Flag  out  4  one-hot {Shift,CMP,Logic,Arith}; marks the unit that produced ALU_OUT.
- Zero_Flag  out  1  ALU_OUT == 0.
- Div_Err  out  1  DIV with B == 0.

## Operation
- S1 (issue register) captures A, B, ALU_FUN on transfer. S2 (output register) holds the result and flags.
- Arith: 00 ADD, 01 SUB. A±B is computed at WIDTH+1 bits and sign-extended to 2W. Carry_OUT is bit WIDTH of the unsigned A±B (SUB: 1 = borrow).
- Arith: 10 MUL, signed, full 2W product, single cycle. 11 DIV, signed.
- DIV result: ALU_OUT = {remainder, quotient}. The quotient truncates toward zero. The remainder takes the sign of A.
- Logic: 00 AND, 01 OR, 10 NAND, 11 NOR. Result is zero-extended to 2W.
- CMP (signed): 00 EQ, 01 GT, 10 LT. The result is 1, 2 or 3 respectively when true, else 0. Op 11 always gives 0.
- Shift on A by B[SHW-1:0]: 00 SRL, 01 SLL, 10 SRA, 11 ROL. Result is zero-extended to 2W. SLL drops overflow bits.
- Divider FSM:
  - IDLE → BUSY when S1 holds a DIV with B ≠ 0. BUSY runs WIDTH restoring iterations on magnitudes, counter WIDTH-1 down to 0.
  - BUSY → DONE when counter = 0. DONE applies signs and loads S2 when S2 is free, then → IDLE.
  - DIV with B == 0 skips BUSY: quotient all ones, remainder = A, Div_Err = 1.
- Reset: all outputs are 0 and IN_READY = 0 while RST is low. Reset mid-division aborts the operation; it is not retried.

## Timing
- Non-DIV latency is 2 edges: accept at edge N, OUT_VALID high after edge N+1.
- Full throughput: one op per cycle with OUT_READY held high.
- DIV latency is WIDTH+3 edges. IN_READY stays low from the edge S1 captures the DIV until S1 drains.
- IN_READY = !S1_valid || (S1 op done && (!OUT_VALID || OUT_READY)). It is combinational, with no combinational path from IN_VALID.
- OUT_VALID with OUT_READY low: ALU_OUT and all flags hold stable, and S1 stalls.
- Simultaneous output transfer and a new S1 result in the same cycle: S2 reloads with no bubble.
- The first IN_READY high is in the cycle after RST rises.

## Configuration
- ALU_DIV_EN defined: divider and its FSM are built as described.
- ALU_DIV_EN undefined: op 0011 completes in 2 edges with ALU_OUT = 0, Div_Err = 1 and Unit_Flag = 0001. No divider logic is built.

## Test plan
- Reset: hold RST low 3 cycles mid-stream → all outputs 0. IN_READY rises one cycle after release.
- ADD, WIDTH=16: A=0x7FFF, B=0x0001 → ALU_OUT=0x00008000, Carry_OUT=0. SUB: A=0, B=1 → ALU_OUT=0xFFFFFFFF, Carry_OUT=1.
- MUL: A=-3, B=5 → ALU_OUT=0xFFFFFFF1. Then back-to-back AND, SRA, LT with OUT_READY=1 → one result per cycle in order.
- DIV: A=-7, B=2 → after 19 edges ALU_OUT={0xFFFF,0xFFFD} (rem -1, quot -3). IN_READY stays low throughout.
- DIV by zero: A=5, B=0 → ALU_OUT={0x0005,0xFFFF}, Div_Err=1, latency 2.
- Backpressure: OUT_READY low 4 cycles after one result → ALU_OUT stable, IN_READY low once S1 is full, no result lost. Repeat with ALU_DIV_EN undefined for DIV → ALU_OUT=0, Div_Err=1.
